// File: rtl/uartrx_maxis.sv
// 8N1 UART receiver that turns whitespace-separated ASCII hex tokens into
// AXI-stream beats; a newline terminator marks the beat with tlast.
module uartrx_maxis #(
  parameter int CLK_DIV    = 434,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  uart_rx,
  output logic                  tvalid,
  input  logic                  tready,
  output logic [DATA_WIDTH-1:0] tdata,
  output logic                  tlast,
  output logic                  frame_err,
  output logic                  overrun
);
  localparam int TX_WIDTH = (DATA_WIDTH + 3) / 4;
  localparam int ACC_W    = TX_WIDTH * 4;
  localparam int CNT_W    = $clog2(CLK_DIV);
  localparam int DCNT_W   = $clog2(TX_WIDTH + 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [DCNT_W-1:0] DCNT_MAX  = DCNT_W'(TX_WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_t;

  // Returns {is_hex, nibble} for one ASCII character.
  function automatic logic [4:0] hex_nibble(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    if (c >= 8'h30 && c <= 8'h39)      r = {1'b1, 4'(c - 8'h30)};
    else if (c >= 8'h41 && c <= 8'h46) r = {1'b1, 4'(c - 8'h37)};
    else if (c >= 8'h61 && c <= 8'h66) r = {1'b1, 4'(c - 8'h57)};
    else                               r = 5'd0;
    return r;
  endfunction

  logic              sync1_r, line_r;
  state_t            state_r, next_state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [2:0]        bit_idx_r;
  logic [7:0]        shreg_r;
  logic              cnt_clr_s, shift_s, stb_s, ferr_s, byte_stb_r;
  logic [ACC_W-1:0]  acc_r, acc_next_s;
  logic [DCNT_W-1:0] dcnt_r, dcnt_next_s;
  logic [4:0]        nib_s;
  logic              emit_s, emit_last_s;

  // RX framing: next state and per-state sampling strobes.
  always_comb begin
    next_state_s = state_r;
    cnt_clr_s    = 1'b0;
    shift_s      = 1'b0;
    stb_s        = 1'b0;
    ferr_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_clr_s = 1'b1;
        if (!line_r) next_state_s = ST_START;
        else         next_state_s = ST_IDLE;
      end
      ST_START: begin
        if (cnt_r == HALF_LAST) begin
          cnt_clr_s = 1'b1;
          if (!line_r) next_state_s = ST_DATA;
          else         next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (cnt_r == BIT_LAST) begin
          cnt_clr_s = 1'b1;
          shift_s   = 1'b1;
          if (bit_idx_r == 3'd7) next_state_s = ST_STOP;
          else                   next_state_s = ST_DATA;
        end else begin
          next_state_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (cnt_r == BIT_LAST) begin
          cnt_clr_s = 1'b1;
          if (line_r) begin
            stb_s        = 1'b1;
            next_state_s = ST_IDLE;
          end else begin
            ferr_s       = 1'b1;
            next_state_s = ST_WAIT_IDLE;
          end
        end else begin
          next_state_s = ST_STOP;
        end
      end
      ST_WAIT_IDLE: begin
        cnt_clr_s = 1'b1;
        if (line_r) next_state_s = ST_IDLE;
        else        next_state_s = ST_WAIT_IDLE;
      end
      default: begin
        cnt_clr_s    = 1'b1;
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Synchronizer, framing state, bit counter and shift register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sync1_r    <= 1'b1;
      line_r     <= 1'b1;
      state_r    <= ST_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      bit_idx_r  <= 3'd0;
      shreg_r    <= 8'd0;
      byte_stb_r <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync1_r    <= uart_rx;
      line_r     <= sync1_r;
      state_r    <= next_state_s;
      cnt_r      <= cnt_clr_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
      if (state_r != ST_DATA) bit_idx_r <= 3'd0;
      else if (shift_s)       bit_idx_r <= bit_idx_r + 3'd1;
      if (shift_s) shreg_r <= {line_r, shreg_r[7:1]};
      byte_stb_r <= stb_s;
      frame_err  <= ferr_s;
    end
  end

  // Token parser; shreg_r is stable here because the next frame is still in its start bit.
  always_comb begin
    nib_s       = hex_nibble(shreg_r);
    acc_next_s  = acc_r;
    dcnt_next_s = dcnt_r;
    emit_s      = 1'b0;
    emit_last_s = 1'b0;
    if (byte_stb_r) begin
      if (nib_s[4]) begin
        acc_next_s = {acc_r[ACC_W-5:0], nib_s[3:0]};
        if (dcnt_r != DCNT_MAX) dcnt_next_s = dcnt_r + DCNT_W'(1);
        else                    dcnt_next_s = dcnt_r;
      end else if (shreg_r == 8'h0D) begin
        acc_next_s = acc_r;
      end else begin
        acc_next_s  = {ACC_W{1'b0}};
        dcnt_next_s = {DCNT_W{1'b0}};
        if (shreg_r == 8'h20 || shreg_r == 8'h09) begin
          emit_s = (dcnt_r != {DCNT_W{1'b0}});
        end else if (shreg_r == 8'h0A) begin
          emit_s      = (dcnt_r != {DCNT_W{1'b0}});
          emit_last_s = 1'b1;
        end else begin
          emit_s = 1'b0;
        end
      end
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Accumulator state and the single-entry output register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc_r   <= {ACC_W{1'b0}};
      dcnt_r  <= {DCNT_W{1'b0}};
      tvalid  <= 1'b0;
      tdata   <= {DATA_WIDTH{1'b0}};
      tlast   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      acc_r   <= acc_next_s;
      dcnt_r  <= dcnt_next_s;
      overrun <= 1'b0;
      if (emit_s && tvalid && !tready) begin
        overrun <= 1'b1;
      end else if (emit_s) begin
        tvalid <= 1'b1;
        tdata  <= acc_r[DATA_WIDTH-1:0];
        tlast  <= emit_last_s;
      end else if (tvalid && tready) begin
        tvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uartrx_maxis.sv
// Bench for uartrx_maxis: serial stimulus, token-level reference model feeding
// a scoreboard queue, and a forked monitor that checks beats on handshake.
module tb_uartrx_maxis;
  localparam int CLK_DIV = 8;
  localparam int DW      = 64;
  localparam int TXW     = (DW + 3) / 4;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          uart_rx = 1'b1;
  logic          tready = 1'b1;
  logic          tvalid, tlast, frame_err, overrun;
  logic [DW-1:0] tdata;

  typedef struct {
    logic [63:0] d;
    logic        l;
  } beat_t;

  beat_t      exp_q[$];
  logic [3:0] tok_q[$];
  int         total = 0;
  int         bad = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;
  bit         model_drop = 1'b0;
  bit         rand_rdy = 1'b0;
  string      hexs = "0123456789abcdefABCDEF";

  uartrx_maxis #(.CLK_DIV(CLK_DIV), .DATA_WIDTH(DW)) dut (
    .aclk(aclk), .aresetn(aresetn), .uart_rx(uart_rx), .tvalid(tvalid),
    .tready(tready), .tdata(tdata), .tlast(tlast), .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  // Reference model: a token is the list of hex digits seen since the last separator.
  task automatic model_byte(input logic [7:0] b);
    logic [63:0] v;
    int d;
    d = -1;
    if (b >= "0" && b <= "9") d = b - "0";
    else if (b >= "A" && b <= "F") d = b - "A" + 10;
    else if (b >= "a" && b <= "f") d = b - "a" + 10;
    if (d >= 0) begin
      tok_q.push_back(4'(d));
      if (tok_q.size() > TXW) void'(tok_q.pop_front());
    end else if (b == 8'h0D) begin
    end else begin
      if ((b == 8'h20 || b == 8'h09 || b == 8'h0A) && tok_q.size() > 0 && !model_drop) begin
        v = 64'd0;
        foreach (tok_q[i]) v = v * 16 + 64'(tok_q[i]);
        exp_q.push_back('{d: v, l: (b == 8'h0A)});
      end
      tok_q.delete();
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
    if (rand_rdy) tready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_bits(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CLK_DIV) tick();
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CLK_DIV) tick();
    end
    uart_rx = stop_bit;
    repeat (CLK_DIV) tick();
    uart_rx = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    send_bits(b, 1'b1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      tick();
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) tick();
  endtask

  task automatic monitor();
    beat_t       e;
    logic        pv, pr, pl;
    logic [63:0] pd;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = 64'd0;
    forever begin
      @(negedge aclk);
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (!aresetn) begin
        pv = 1'b0;
      end else begin
        if (tvalid && pv && !pr) begin
          check("hold_data", tdata, pd);
          check("hold_last", 64'(tlast), 64'(pl));
        end
        if (tvalid && tready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat got=%h required=none", tdata);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", tdata, e.d);
            check("beat_last", 64'(tlast), 64'(e.l));
          end
        end
        pv = tvalid; pr = tready; pd = tdata; pl = tlast;
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    repeat (3) @(posedge aclk);
    #1;
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_tdata", tdata, 64'd0);
    check("rst_tlast", 64'(tlast), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    aresetn = 1'b1;
    repeat (4) tick();

    // 1: single token ending in newline
    send_str("1A2b\n");
    drain();
    check("t1_ferr", 64'(ferr_cnt), 64'd0);
    check("t1_ovr", 64'(ovr_cnt), 64'd0);

    // 2: two tokens, CR ignored, empty line produces nothing
    send_str("12 34\r\n\n");
    drain();

    // 3: 17 digits keep only the last 16
    send_str("123456789ABCDEF01 ");
    drain();

    // 4: bad stop bit discards the byte
    send_bits(8'h35, 1'b0);
    repeat (2 * CLK_DIV) tick();
    check("t4_ferr", 64'(ferr_cnt), 64'd1);
    send_str("7\n");
    drain();
    check("t4_ferr_once", 64'(ferr_cnt), 64'd1);

    // 5: back-pressure and overrun
    tready = 1'b0;
    send_str("1 ");
    repeat (4) tick();
    check("t5_valid", 64'(tvalid), 64'd1);
    check("t5_data", tdata, 64'd1);
    model_drop = 1'b1;
    send_str("2 ");
    model_drop = 1'b0;
    repeat (4) tick();
    check("t5_ovr", 64'(ovr_cnt), 64'd1);
    check("t5_held", tdata, 64'd1);
    check("t5_valid_held", 64'(tvalid), 64'd1);
    tready = 1'b1;
    tick();
    tick();
    check("t5_drained", 64'(tvalid), 64'd0);
    check("t5_q_empty", 64'(exp_q.size()), 64'd0);

    // 6: glitch rejection, other-char discard
    uart_rx = 1'b0;
    repeat (CLK_DIV / 2 - 2) tick();
    uart_rx = 1'b1;
    repeat (2 * CLK_DIV) tick();
    send_str("G5 6\n");
    drain();
    check("t6_ferr", 64'(ferr_cnt), 64'd1);

    // 6b: reset mid-byte with a held beat and partial token
    tready = 1'b0;
    model_drop = 1'b1;
    send_str("9 ab");
    model_drop = 1'b0;
    repeat (2) tick();
    check("t6_pre_valid", 64'(tvalid), 64'd1);
    check("t6_pre_data", tdata, 64'd9);
    uart_rx = 1'b0;
    repeat (20) tick();
    #2 aresetn = 1'b0;
    #1;
    check("t6_rst_tvalid", 64'(tvalid), 64'd0);
    check("t6_rst_tdata", tdata, 64'd0);
    check("t6_rst_tlast", 64'(tlast), 64'd0);
    check("t6_rst_ferr", 64'(frame_err), 64'd0);
    check("t6_rst_ovr", 64'(overrun), 64'd0);
    tok_q.delete();
    uart_rx = 1'b1;
    repeat (5) tick();
    aresetn = 1'b1;
    tready = 1'b1;
    repeat (3) tick();
    send_str("c\n");
    drain();

    // randomized tokens with random back-pressure
    rand_rdy = 1'b1;
    for (int t = 0; t < 30; t++) begin
      int nd;
      nd = $urandom_range(1, 20);
      for (int k = 0; k < nd; k++) send_byte(hexs[$urandom_range(0, 21)]);
      case ($urandom_range(0, 5))
        0: send_byte(8'h20);
        1: send_byte(8'h09);
        2: send_byte(8'h0A);
        3: begin send_byte(8'h0D); send_byte(8'h0A); end
        4: begin send_byte(8'h20); send_byte(8'h20); end
        default: send_byte(8'h5A);
      endcase
    end
    send_byte(8'h0A);
    drain();
    rand_rdy = 1'b0;
    tready = 1'b1;
    repeat (4) tick();
    check("end_ferr", 64'(ferr_cnt), 64'd1);
    check("end_ovr", 64'(ovr_cnt), 64'd1);
    check("end_idle", 64'(tvalid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
